// File: rtl/rr_arbiter8.sv
// Registered 8-way round-robin arbiter feeding a 3-to-8 decoder.
// Holds each grant until done, request drop, or the MAX_HOLD cycle limit.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state, state_next;
  logic [2:0]         ptr, ptr_next;
  logic [2:0]         idx_next;
  logic [CNT_W-1:0]   hold_cnt, cnt_next;
  logic               valid_next, timeout_next;
  logic               any_req, drop, hold_hit;
  logic [2:0]         winner;

  // Scan ptr, ptr+1, ... ptr+7 (mod 8); the closest requester to ptr wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] w;
    w = p;
    for (int k = 7; k >= 0; k--) begin
      if (r[p + 3'(k)]) w = p + 3'(k);
    end
    return w;
  endfunction

  assign any_req  = |req;
  assign winner   = rr_pick(req, ptr);
  assign drop     = !req[gnt_idx];
  assign hold_hit = TIMEOUT_EN && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      hold_cnt  <= cnt_next;
      gnt_valid <= valid_next;
      gnt_idx   <= idx_next;
      timeout   <= timeout_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = GRANT;
      GRANT:   if (done || drop || hold_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Release priority in GRANT: done, then request drop, then hold limit.
  always_comb begin
    valid_next   = gnt_valid;
    idx_next     = gnt_idx;
    ptr_next     = ptr;
    cnt_next     = hold_cnt;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          valid_next = 1'b1;
          idx_next   = winner;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (done || drop || hold_hit) begin
          valid_next   = 1'b0;
          ptr_next     = gnt_idx + 3'd1;
          timeout_next = !done && !drop;
        end else if (hold_cnt != '1) begin
          cnt_next = hold_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic checked
// against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 15;
  localparam int CNT_W    = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic       done  = 1'b0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  bit         m_valid;
  logic [2:0] m_idx;
  bit         m_to;
  int         m_ptr;
  int         m_held;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 3'd0;
    m_to    = 1'b0;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  task automatic model_step();
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_to = 1'b0;
    if (!m_valid) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_idx   = 3'(w);
        m_held  = 1;
      end
    end else if (done || !req[m_idx] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
      m_to    = !done && req[m_idx];
      m_valid = 1'b0;
      m_ptr   = (int'(m_idx) + 1) % 8;
    end else begin
      m_held++;
    end
  endtask

  // Advance one clock edge; model sees the same inputs as the DUT.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) begin
      tick();
      if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: got v=%0b i=%0d t=%0b want v=0 i=0 t=0", gnt_valid, gnt_idx, timeout);
      end
      vectors++;
    end
    rst_n = 1'b1;
    req   = 8'h10;
    tick();
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd4 || gnt_idx !== m_idx) begin
      miscompares++;
      $display("FAIL reset_first_grant: got v=%0b i=%0d want v=1 i=4", gnt_valid, gnt_idx);
    end
    vectors++;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got v=%0b i=%0d t=%0b want v=0 i=0 t=0", gnt_valid, gnt_idx, timeout);
    end
    vectors++;
    #1 rst_n = 1'b1;
    req = 8'hFF;
    tick();
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || gnt_idx !== m_idx) begin
      miscompares++;
      $display("FAIL reset_regrant: got v=%0b i=%0d want v=1 i=0", gnt_valid, gnt_idx);
    end
    vectors++;
  endtask

  task automatic test_single();
    do_reset();
    req = 8'b0010_0000;
    tick();
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL single_grant: got v=%0b i=%0d t=%0b want v=1 i=5 t=0", gnt_valid, gnt_idx, timeout);
    end
    vectors++;
    repeat (2) begin
      tick();
      if (gnt_valid !== m_valid || gnt_idx !== m_idx || timeout !== m_to) begin
        miscompares++;
        $display("FAIL single_hold: got v=%0b i=%0d want v=%0b i=%0d", gnt_valid, gnt_idx, m_valid, m_idx);
      end
      vectors++;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    if (gnt_valid !== 1'b0 || gnt_idx !== 3'd5 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: got v=%0b i=%0d t=%0b want v=0 i=5 t=0", gnt_valid, gnt_idx, timeout);
    end
    vectors++;
    req = 8'hFF;
    tick();
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6) begin
      miscompares++;
      $display("FAIL single_ptr: got v=%0b i=%0d want v=1 i=6", gnt_valid, gnt_idx);
    end
    vectors++;
  endtask

  task automatic test_rotation();
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'(i % 8) || gnt_idx !== m_idx) begin
        miscompares++;
        $display("FAIL rotation_grant%0d: got v=%0b i=%0d want v=1 i=%0d", i, gnt_valid, gnt_idx, i % 8);
      end
      vectors++;
      done = 1'b1;
      tick();
      done = 1'b0;
      if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL rotation_gap%0d: got v=%0b t=%0b want v=0 t=0", i, gnt_valid, timeout);
      end
      vectors++;
    end
  endtask

  task automatic test_wrap();
    logic [2:0] want [3];
    want[0] = 3'd6;
    want[1] = 3'd0;
    want[2] = 3'd1;
    do_reset();
    req = 8'b0100_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt_valid !== 1'b1 || gnt_idx !== want[i] || gnt_idx !== m_idx) begin
        miscompares++;
        $display("FAIL wrap_grant%0d: got v=%0b i=%0d want v=1 i=%0d", i, gnt_valid, gnt_idx, want[i]);
      end
      vectors++;
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 8'b0000_0011;
    end
  endtask

  task automatic test_timeout();
    int held;
    do_reset();
    req = 8'h18;
    tick();
    held = 0;
    for (int n = 0; n < 40 && gnt_valid === 1'b1; n++) begin
      held++;
      tick();
      if (gnt_valid !== m_valid || gnt_idx !== m_idx || timeout !== m_to) begin
        miscompares++;
        $display("FAIL timeout_track: got v=%0b i=%0d t=%0b want v=%0b i=%0d t=%0b",
                 gnt_valid, gnt_idx, timeout, m_valid, m_idx, m_to);
      end
      vectors++;
    end
    if (held != MAX_HOLD || timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_len: got held=%0d t=%0b want held=%0d t=1", held, timeout, MAX_HOLD);
    end
    vectors++;
    tick();
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd4 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_next: got v=%0b i=%0d t=%0b want v=1 i=4 t=0", gnt_valid, gnt_idx, timeout);
    end
    vectors++;
    repeat (MAX_HOLD - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0 || timeout !== m_to) begin
      miscompares++;
      $display("FAIL timeout_vs_done: got v=%0b t=%0b want v=0 t=0", gnt_valid, timeout);
    end
    vectors++;
  endtask

  task automatic test_drop();
    do_reset();
    req = 8'h04;
    tick();
    tick();
    req = 8'b1000_1011;
    tick();
    if (gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 3'd2) begin
      miscompares++;
      $display("FAIL drop_release: got v=%0b i=%0d t=%0b want v=0 i=2 t=0", gnt_valid, gnt_idx, timeout);
    end
    vectors++;
    tick();
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || gnt_idx !== m_idx) begin
      miscompares++;
      $display("FAIL drop_next: got v=%0b i=%0d want v=1 i=3", gnt_valid, gnt_idx);
    end
    vectors++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 15) == 0) req = 8'h00;
      done = ($urandom_range(0, 9) == 0);
      tick();
      if (gnt_valid !== m_valid || gnt_idx !== m_idx || timeout !== m_to) begin
        miscompares++;
        $display("FAIL random%0d: got v=%0b i=%0d t=%0b want v=%0b i=%0d t=%0b",
                 n, gnt_valid, gnt_idx, timeout, m_valid, m_idx, m_to);
      end
      vectors++;
    end
    done = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
